// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: default widths,
// the lock FSM state encoding and the o_owner packing.
package sram_arb_pkg;

   localparam int SRAM_DATA_W = 256;
   localparam int SRAM_ADDR_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_LOCK0 = 2'd1,
      ARB_LOCK1 = 2'd2
   } arb_lock_state_t;

   // Requester identities as they appear in o_owner[0]
   localparam logic OWNER_R0 = 1'b0;
   localparam logic OWNER_R1 = 1'b1;

   // o_owner = {lock active, last granted requester}
   function automatic logic [1:0] pack_owner(input logic lock_active,
                                             input logic requester);
      return {lock_active, requester};
   endfunction

endpackage

// File: rtl/sram_arb_rd_pipe.sv
// Read-return tracker: carries the valid flag and requester id of each
// issued SRAM read for READ_LATENCY cycles so the data-valid strobe lines
// up with the SRAM readdata and lands on the requester that asked for it.
module sram_arb_rd_pipe
   import sram_arb_pkg::*;
#(
   parameter int READ_LATENCY = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic issue_valid,
   input  logic issue_owner,
   output logic rvalid0,
   output logic rvalid1
);

   logic [READ_LATENCY-1:0] vld;
   logic [READ_LATENCY-1:0] own;

   // Shift the read tag along one stage per cycle; reset drops every read in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         own <= '0;
      end else begin
         vld[0] <= issue_valid;
         own[0] <= issue_owner;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            own[i] <= own[i-1];
         end
      end
   end

   assign rvalid0 = vld[READ_LATENCY-1] && (own[READ_LATENCY-1] == OWNER_R0);
   assign rvalid1 = vld[READ_LATENCY-1] && (own[READ_LATENCY-1] == OWNER_R1);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester SRAM port arbiter (r0 = matrix engine, r1 = host loader).
// Round-robin grant, one access per cycle, registered SRAM command and a
// tagged read-return pipeline. Optional ownership locking is compiled in
// when the macro SRAM_ARB_LOCK_EN is defined; without it the lock inputs
// have no effect and the lock FSM stays in ARB_IDLE.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_W       = SRAM_DATA_W,
   parameter int ADDR_W       = SRAM_ADDR_W,
   parameter int READ_LATENCY = 1
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   input  logic              i_lock0,
   input  logic              i_lock1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_rvalid0,
   output logic              o_rvalid1,
   output logic [DATA_W-1:0] o_rdata,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_wr_en,
   output logic [DATA_W-1:0] o_sram_wdata,
   input  logic [DATA_W-1:0] i_sram_rdata,
   output logic [1:0]        o_owner
);

   arb_lock_state_t   lock_state;
   arb_lock_state_t   lock_state_next;
   logic              rr_last;
   logic              lock_hold0;
   logic              lock_hold1;
   logic              gnt0;
   logic              gnt1;
   logic              any_gnt;
   logic              sel_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              cmd_rd_valid;
   logic              cmd_rd_owner;
   logic              rvalid0;
   logic              rvalid1;

   // A lock only binds while its owner keeps the lock line high; the cycle it
   // drops, arbitration falls back to plain round robin.
   assign lock_hold0 = (lock_state == ARB_LOCK0) && i_lock0;
   assign lock_hold1 = (lock_state == ARB_LOCK1) && i_lock1;

   // Grant selection: lock owner first, otherwise the requester that did not win last
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!i_rst) begin
         if (lock_hold0) begin
            gnt0 = i_req0;
         end else if (lock_hold1) begin
            gnt1 = i_req1;
         end else if (i_req0 && i_req1) begin
            if (rr_last == OWNER_R1) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
         end
      end
   end

   assign o_gnt0    = gnt0;
   assign o_gnt1    = gnt1;
   assign any_gnt   = gnt0 || gnt1;
   assign sel_id    = gnt1 ? OWNER_R1 : OWNER_R0;
   assign sel_we    = gnt1 ? i_we1    : i_we0;
   assign sel_addr  = gnt1 ? i_addr1  : i_addr0;
   assign sel_wdata = gnt1 ? i_wdata1 : i_wdata0;

   // Lock FSM next state; a lock taken with a grant applies from the next cycle
   always_comb begin
      lock_state_next = ARB_IDLE;
`ifdef SRAM_ARB_LOCK_EN
      if (lock_hold0) begin
         lock_state_next = ARB_LOCK0;
      end else if (lock_hold1) begin
         lock_state_next = ARB_LOCK1;
      end else if (gnt0 && i_lock0) begin
         lock_state_next = ARB_LOCK0;
      end else if (gnt1 && i_lock1) begin
         lock_state_next = ARB_LOCK1;
      end
`endif
   end

   // Arbitration state: lock FSM, round-robin pointer and the owner status word
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lock_state <= ARB_IDLE;
         rr_last    <= OWNER_R1;
         o_owner    <= '0;
      end else begin
         lock_state <= lock_state_next;
         if (any_gnt) begin
            rr_last <= sel_id;
         end
         o_owner <= pack_owner(lock_state_next != ARB_IDLE,
                               any_gnt ? sel_id : o_owner[0]);
      end
   end

   // Registered SRAM command; address and write data hold when nothing is granted
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_sram_addr  <= '0;
         o_sram_wr_en <= 1'b0;
         o_sram_wdata <= '0;
         cmd_rd_valid <= 1'b0;
         cmd_rd_owner <= OWNER_R0;
      end else begin
         o_sram_wr_en <= any_gnt && sel_we;
         cmd_rd_valid <= any_gnt && !sel_we;
         cmd_rd_owner <= sel_id;
         if (any_gnt) begin
            o_sram_addr <= sel_addr;
            if (sel_we) begin
               o_sram_wdata <= sel_wdata;
            end
         end
      end
   end

   sram_arb_rd_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk         (i_clk),
      .rst         (i_rst),
      .issue_valid (cmd_rd_valid),
      .issue_owner (cmd_rd_owner),
      .rvalid0     (rvalid0),
      .rvalid1     (rvalid1)
   );

   assign o_rvalid0 = rvalid0;
   assign o_rvalid1 = rvalid1;

   // Readdata is shared; it is forced to zero whenever no read is returning
   assign o_rdata = (rvalid0 || rvalid1) ? i_sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter. Two instances (READ_LATENCY 1
// and 2) share one stimulus stream; a transaction-level model predicts
// grants, SRAM commands, owner status and read returns per cycle.
module tb_sram_port_arbiter;

   localparam int DW   = 256;
   localparam int AW   = 4;
   localparam int NCYC = 1024;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          lock;
   } cmd_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic          lock0 = 1'b0, lock1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;

   logic          gnt0_a, gnt1_a, rv0_a, rv1_a, wren_a;
   logic          gnt0_b, gnt1_b, rv0_b, rv1_b, wren_b;
   logic [DW-1:0] rdata_a, wdata_a, srd_a, rdata_b, wdata_b, srd_b;
   logic [AW-1:0] saddr_a, saddr_b;
   logic [1:0]    owner_a, owner_b;

   logic [DW-1:0] mem_a [0:15];
   logic [DW-1:0] mem_b [0:15];
   logic [DW-1:0] rd_b1;
   logic [DW-1:0] model_mem [0:15];

   logic [1:0]    exp_rv_a [0:NCYC-1];
   logic [1:0]    exp_rv_b [0:NCYC-1];
   logic [DW-1:0] exp_rd_a [0:NCYC-1];
   logic [DW-1:0] exp_rd_b [0:NCYC-1];
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   logic          exp_wren;
   logic [1:0]    exp_owner;
   int            last_win;
   int            lock_owner;
   bit            model_known = 1'b0;
   bit            rst_now = 1'b1;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   cmd_t          q0 [$];
   cmd_t          q1 [$];

   always #5 clock = ~clock;

   sram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1)) dut_a (
      .i_clk(clock), .i_rst(reset),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .i_lock0(lock0), .i_lock1(lock1),
      .o_gnt0(gnt0_a), .o_gnt1(gnt1_a), .o_rvalid0(rv0_a), .o_rvalid1(rv1_a),
      .o_rdata(rdata_a), .o_sram_addr(saddr_a), .o_sram_wr_en(wren_a),
      .o_sram_wdata(wdata_a), .i_sram_rdata(srd_a), .o_owner(owner_a)
   );

   sram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2)) dut_b (
      .i_clk(clock), .i_rst(reset),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .i_lock0(lock0), .i_lock1(lock1),
      .o_gnt0(gnt0_b), .o_gnt1(gnt1_b), .o_rvalid0(rv0_b), .o_rvalid1(rv1_b),
      .o_rdata(rdata_b), .o_sram_addr(saddr_b), .o_sram_wr_en(wren_b),
      .o_sram_wdata(wdata_b), .i_sram_rdata(srd_b), .o_owner(owner_b)
   );

   // SRAM behind each instance: synchronous write, 1- or 2-cycle read
   always @(posedge clock) begin
      if (wren_a === 1'b1) mem_a[saddr_a] <= wdata_a;
      srd_a <= mem_a[saddr_a];
      if (wren_b === 1'b1) mem_b[saddr_b] <= wdata_b;
      rd_b1 <= mem_b[saddr_b];
      srd_b <= rd_b1;
   end

   function automatic logic [DW-1:0] rand256();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
                  tag, cyc, observed, expected);
      end
   endtask

   task automatic pushCmd(input int who, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic lock);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = wdata; c.lock = lock;
      if (who == 0) q0.push_back(c);
      else          q1.push_back(c);
   endtask

   // One clock cycle: present queue heads, check the DUTs, advance the model
   task automatic applyStimulus();
      cmd_t c0, c1, cg;
      bit   r0, r1, g0, g1;
      int   held, n;
      @(negedge clock);
      r0 = q0.size() > 0;
      r1 = q1.size() > 0;
      if (r0) c0 = q0[0];
      else begin c0.we = 1'($urandom_range(0, 1)); c0.addr = 4'($urandom_range(0, 15)); c0.wdata = rand256(); c0.lock = 1'b0; end
      if (r1) c1 = q1[0];
      else begin c1.we = 1'($urandom_range(0, 1)); c1.addr = 4'($urandom_range(0, 15)); c1.wdata = rand256(); c1.lock = 1'b0; end
      reset = rst_now;
      req0 = r0; we0 = c0.we; addr0 = c0.addr; wdata0 = c0.wdata; lock0 = c0.lock;
      req1 = r1; we1 = c1.we; addr1 = c1.addr; wdata1 = c1.wdata; lock1 = c1.lock;
      #1;

      g0 = 1'b0; g1 = 1'b0; held = -1;
      if (lock_owner == 0 && c0.lock) held = 0;
      else if (lock_owner == 1 && c1.lock) held = 1;
      if (!rst_now) begin
         if (held == 0) g0 = r0;
         else if (held == 1) g1 = r1;
         else if (r0 && r1) begin
            if (last_win == 0) g1 = 1'b1; else g0 = 1'b1;
         end else begin
            g0 = r0; g1 = r1;
         end
      end
      checkOutput("gnt0_a", gnt0_a, g0);
      checkOutput("gnt1_a", gnt1_a, g1);
      checkOutput("gnt0_b", gnt0_b, g0);
      checkOutput("gnt1_b", gnt1_b, g1);

      if (model_known) begin
         checkOutput("wren_a", wren_a, exp_wren);
         checkOutput("wren_b", wren_b, exp_wren);
         checkOutput("addr_a", saddr_a, exp_addr);
         checkOutput("addr_b", saddr_b, exp_addr);
         if (exp_wren) begin
            checkOutput("wdata_a", wdata_a, exp_wdata);
            checkOutput("wdata_b", wdata_b, exp_wdata);
         end
         checkOutput("owner_a", owner_a, exp_owner);
         checkOutput("owner_b", owner_b, exp_owner);
         checkOutput("rvalid0_a", rv0_a, exp_rv_a[cyc][0]);
         checkOutput("rvalid1_a", rv1_a, exp_rv_a[cyc][1]);
         checkOutput("rvalid0_b", rv0_b, exp_rv_b[cyc][0]);
         checkOutput("rvalid1_b", rv1_b, exp_rv_b[cyc][1]);
         if (exp_rv_a[cyc] != 2'b00) checkOutput("rdata_a", rdata_a, exp_rd_a[cyc]);
         if (exp_rv_b[cyc] != 2'b00) checkOutput("rdata_b", rdata_b, exp_rd_b[cyc]);
      end

      if (rst_now) begin
         exp_wren = 1'b0; exp_addr = '0; exp_wdata = '0; exp_owner = 2'b00;
         last_win = 1; lock_owner = -1; model_known = 1'b1;
         for (int k = cyc + 1; k < NCYC; k++) begin
            exp_rv_a[k] = 2'b00;
            exp_rv_b[k] = 2'b00;
         end
      end else begin
`ifdef SRAM_ARB_LOCK_EN
         if (held < 0) begin
            if (g0 && c0.lock) lock_owner = 0;
            else if (g1 && c1.lock) lock_owner = 1;
            else lock_owner = -1;
         end
`else
         lock_owner = -1;
`endif
         exp_wren = 1'b0;
         if (g0 || g1) begin
            n  = g1 ? 1 : 0;
            cg = g1 ? c1 : c0;
            last_win = n;
            exp_addr = cg.addr;
            exp_owner[0] = n[0];
            if (cg.we) begin
               exp_wren = 1'b1;
               exp_wdata = cg.wdata;
               model_mem[cg.addr] = cg.wdata;
            end else begin
               if (cyc + 2 < NCYC) begin
                  exp_rv_a[cyc+2][n] = 1'b1;
                  exp_rd_a[cyc+2] = model_mem[cg.addr];
               end
               if (cyc + 3 < NCYC) begin
                  exp_rv_b[cyc+3][n] = 1'b1;
                  exp_rd_b[cyc+3] = model_mem[cg.addr];
               end
            end
            if (g0) void'(q0.pop_front());
            else    void'(q1.pop_front());
         end
         exp_owner[1] = (lock_owner >= 0);
      end
      cyc++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      logic [DW-1:0] w;
      for (int i = 0; i < 16; i++) begin
         w = (i == 3) ? {32{8'hA5}} : rand256();
         mem_a[i] = w; mem_b[i] = w; model_mem[i] = w;
      end
      for (int k = 0; k < NCYC; k++) begin
         exp_rv_a[k] = 2'b00; exp_rv_b[k] = 2'b00;
         exp_rd_a[k] = '0;    exp_rd_b[k] = '0;
      end
      last_win = 1; lock_owner = -1;
      exp_wren = 1'b0; exp_addr = '0; exp_wdata = '0; exp_owner = 2'b00;

      rst_now = 1'b1;
      runCycles(3);
      rst_now = 1'b0;

      $display("[TB] single read of addr 3");
      pushCmd(0, 1'b0, 4'd3, '0, 1'b0);
      runCycles(5);

      $display("[TB] contention, both requesters reading");
      for (int i = 0; i < 3; i++) begin
         pushCmd(0, 1'b0, 4'(i + 1), '0, 1'b0);
         pushCmd(1, 1'b0, 4'(i + 9), '0, 1'b0);
      end
      runCycles(10);

      $display("[TB] r1 write then r0 read of addr 7");
      pushCmd(1, 1'b1, 4'd7, 256'h1234, 1'b0);
      runCycles(1);
      pushCmd(0, 1'b0, 4'd7, '0, 1'b0);
      runCycles(6);

      $display("[TB] r0 locked burst with r1 waiting");
      pushCmd(0, 1'b0, 4'd2, '0, 1'b1);
      pushCmd(0, 1'b1, 4'd5, rand256(), 1'b1);
      pushCmd(0, 1'b0, 4'd5, '0, 1'b1);
      pushCmd(0, 1'b0, 4'd7, '0, 1'b1);
      runCycles(1);
      for (int i = 0; i < 3; i++) pushCmd(1, 1'b0, 4'(i + 12), '0, 1'b0);
      runCycles(12);

      $display("[TB] reset with a read in flight");
      pushCmd(0, 1'b0, 4'd3, '0, 1'b0);
      runCycles(1);
      rst_now = 1'b1;
      runCycles(1);
      rst_now = 1'b0;
      runCycles(5);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 500; i++) begin
         if (q0.size() == 0 && $urandom_range(0, 2) != 0)
            pushCmd(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand256(),
                    $urandom_range(0, 3) == 0);
         if (q1.size() == 0 && $urandom_range(0, 2) != 0)
            pushCmd(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand256(),
                    $urandom_range(0, 3) == 0);
         applyStimulus();
      end
      q0.delete();
      q1.delete();
      runCycles(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
